// File: rtl/adder_seq.sv
// adder_seq: multi-cycle adder that sums WIDTH-bit operands CHUNK bits per
// clock. A start request latches the operands. The chunks are then added
// least-significant first, and the carry is held in a register between chunks.
// The registered sum and carry-out change only when the final chunk completes.
//
// Optional feature: define ADDER_SEQ_SUBTRACT_EN to add a 'sub' input port.
// With sub=1 the block computes in_1 + ~in_2 + 1. In that mode carry_out=1
// means there was no borrow.
module adder_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic             carry_in,
`ifdef ADDER_SEQ_SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out_put,
  output logic             carry_out
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  // Reject configurations that cannot be split into whole chunks.
  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("adder_seq: CHUNK must divide WIDTH and satisfy 1 <= CHUNK <= WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;      // operands, shifted down one chunk per step
  logic [WIDTH-1:0]   sum_q;         // partial sum, filled from the top down
  logic               carry_q;       // carry between chunks
  logic [CNT_W-1:0]   cnt_q;         // index of the chunk being added

  logic               accept;
  logic               last_chunk;
  logic [CHUNK:0]     chunk_sum;
  logic [WIDTH-1:0]   chunk_ext;
  logic [WIDTH-1:0]   sum_next;
  logic [WIDTH-1:0]   b_load;
  logic               carry_load;

  // A start request is honoured in IDLE and DONE. It is ignored while running.
  assign accept     = start && (state_q != RUN);
  assign last_chunk = (cnt_q == CNT_W'(N - 1));

  // Add the low chunk of the shifted operands plus the carry that was held.
  assign chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry_q};

  // Shift the partial sum down and insert the new chunk at the top.
  // After N steps, chunk 0 ends up at bit 0.
  assign chunk_ext = WIDTH'(chunk_sum[CHUNK-1:0]);
  assign sum_next  = (sum_q >> CHUNK) | (chunk_ext << (WIDTH - CHUNK));

  // Select the operand and carry that are loaded at start.
  // Subtraction is stored as an inverted second operand with a forced carry.
`ifdef ADDER_SEQ_SUBTRACT_EN
  assign b_load     = sub ? ~in_2 : in_2;
  assign carry_load = sub ? 1'b1 : carry_in;
`else
  assign b_load     = in_2;
  assign carry_load = carry_in;
`endif

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic and status outputs decoded from the current state.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_chunk) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, then add one chunk per RUN cycle.
  // The visible result is written only on the last chunk.
  always_ff @(posedge clk) begin
    // NOTE: every datapath register is reset. Reset clears the counter, the
    // carry, the result and any partial sum from an aborted operation.
    if (!reset_n) begin
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      out_put   <= '0;
      carry_out <= 1'b0;
    end else if (accept) begin
      a_q     <= in_1;
      b_q     <= b_load;
      carry_q <= carry_load;
      sum_q   <= '0;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      a_q     <= a_q >> CHUNK;
      b_q     <= b_q >> CHUNK;
      sum_q   <= sum_next;
      carry_q <= chunk_sum[CHUNK];
      cnt_q   <= cnt_q + CNT_W'(1);
      if (last_chunk) begin
        out_put   <= sum_next;
        carry_out <= chunk_sum[CHUNK];
      end
    end
  end

endmodule

// File: tb/tb_adder_seq.sv
// tb_adder_seq: directed-vector bench for adder_seq.
// The main instance uses WIDTH=32 and CHUNK=8. A second instance uses
// CHUNK=32 and checks single-cycle latency, plus subtraction when
// ADDER_SEQ_SUBTRACT_EN is defined.
module tb_adder_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] in_1, in_2;
  logic        carry_in;
  logic        busy, done, carry_out;
  logic [31:0] out_put;

  logic        start_w;
  logic [31:0] in_1_w, in_2_w;
  logic        carry_in_w;
  logic        busy_w, done_w, carry_out_w;
  logic [31:0] out_put_w;
`ifdef ADDER_SEQ_SUBTRACT_EN
  logic        sub_w;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] prev_sum;
  logic        prev_c;

  adder_seq #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .in_1      (in_1),
    .in_2      (in_2),
    .carry_in  (carry_in),
`ifdef ADDER_SEQ_SUBTRACT_EN
    .sub       (1'b0),
`endif
    .busy      (busy),
    .done      (done),
    .out_put   (out_put),
    .carry_out (carry_out)
  );

  adder_seq #(.WIDTH(32), .CHUNK(32)) u_dut_w (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start_w),
    .in_1      (in_1_w),
    .in_2      (in_2_w),
    .carry_in  (carry_in_w),
`ifdef ADDER_SEQ_SUBTRACT_EN
    .sub       (sub_w),
`endif
    .busy      (busy_w),
    .done      (done_w),
    .out_put   (out_put_w),
    .carry_out (carry_out_w)
  );

  always #5 clk = ~clk;

  // Watchdog: the directed sequence is short, so this only fires on a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one addition on the CHUNK=8 instance.
  // Busy must last 4 cycles and the old result must hold during RUN.
  // After those 4 cycles, a single-cycle done pulse must carry the new result.
  // The operands are scrambled right after acceptance.
  task automatic run_add(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic [31:0] exp_sum, input logic exp_c);
    in_1 = a; in_2 = b; carry_in = cin; start = 1'b1;
    tick();
    start = 1'b0;
    in_1 = $urandom; in_2 = $urandom; carry_in = ~cin;
    for (int i = 0; i < 4; i++) begin
      check({tag, "_busy"}, 64'(busy), 64'(1'b1));
      check({tag, "_nodone"}, 64'(done), 64'(1'b0));
      check({tag, "_hold"}, 64'({prev_c, prev_sum}), 64'({carry_out, out_put}));
      tick();
    end
    check({tag, "_done"}, 64'(done), 64'(1'b1));
    check({tag, "_idle"}, 64'(busy), 64'(1'b0));
    check({tag, "_sum"}, 64'(out_put), 64'(exp_sum));
    check({tag, "_cout"}, 64'(carry_out), 64'(exp_c));
    tick();
    check({tag, "_pulse"}, 64'(done), 64'(1'b0));
    prev_sum = exp_sum;
    prev_c   = exp_c;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; in_1 = '0; in_2 = '0; carry_in = 1'b0;
    start_w = 1'b0; in_1_w = '0; in_2_w = '0; carry_in_w = 1'b0;
`ifdef ADDER_SEQ_SUBTRACT_EN
    sub_w = 1'b0;
`endif
    prev_sum = '0; prev_c = 1'b0;

    // Reset state, with start asserted to confirm that reset wins.
    tick();
    start = 1'b1;
    tick();
    check("rst_busy", 64'(busy), 64'(1'b0));
    check("rst_done", 64'(done), 64'(1'b0));
    check("rst_sum", 64'(out_put), 64'h0);
    check("rst_cout", 64'(carry_out), 64'(1'b0));
    start = 1'b0;
    reset_n = 1'b1;
    tick();

    // Basic, wrap-around, cross-chunk carry and mixed patterns.
    run_add("basic", 32'h1, 32'h1, 1'b0, 32'h2, 1'b0);
    run_add("wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1);
    run_add("cprop", 32'h0000_00FF, 32'h0, 1'b1, 32'h0000_0100, 1'b0);
    run_add("mixed", 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0);
    run_add("topc", 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0001, 1'b1);

    // Start during RUN is ignored. A restart on the done cycle has no idle gap.
    in_1 = 32'd10; in_2 = 32'd20; carry_in = 1'b0; start = 1'b1;
    tick();                               // accept
    start = 1'b0;
    tick();                               // RUN edge 1
    in_1 = 32'd3; in_2 = 32'd4; start = 1'b1;
    tick();                               // RUN edge 2: start ignored
    start = 1'b0;
    check("ign_busy", 64'(busy), 64'(1'b1));
    tick();
    tick();
    check("ign_done", 64'(done), 64'(1'b1));
    check("ign_sum", 64'(out_put), 64'd30);
    in_1 = 32'd5; in_2 = 32'd6; start = 1'b1;
    tick();                               // restart accepted in DONE
    start = 1'b0;
    check("rs_busy", 64'(busy), 64'(1'b1));
    check("rs_nodone", 64'(done), 64'(1'b0));
    check("rs_hold", 64'(out_put), 64'd30);
    tick(); tick(); tick();
    check("rs_early", 64'(done), 64'(1'b0));
    tick();
    check("rs_done", 64'(done), 64'(1'b1));
    check("rs_sum", 64'(out_put), 64'd11);
    tick();

    // Reset at RUN edge 2 aborts the operation, and no done may follow.
    in_1 = 32'd7; in_2 = 32'd8; start = 1'b1;
    tick();
    start = 1'b0;
    tick();                               // RUN edge 1
    reset_n = 1'b0;
    tick();                               // RUN edge 2 with reset
    reset_n = 1'b1;
    check("abort_busy", 64'(busy), 64'(1'b0));
    check("abort_done", 64'(done), 64'(1'b0));
    check("abort_sum", 64'(out_put), 64'h0);
    check("abort_cout", 64'(carry_out), 64'(1'b0));
    for (int i = 0; i < 5; i++) begin
      check("abort_nodone", 64'(done), 64'(1'b0));
      tick();
    end
    prev_sum = '0; prev_c = 1'b0;
    run_add("post", 32'd1, 32'd2, 1'b0, 32'd3, 1'b0);

    // CHUNK=WIDTH instance: done arrives one cycle after start.
    in_1_w = 32'd5; in_2_w = 32'd3; carry_in_w = 1'b1; start_w = 1'b1;
    tick();
    start_w = 1'b0;
    check("w_busy", 64'(busy_w), 64'(1'b1));
    tick();
    check("w_done", 64'(done_w), 64'(1'b1));
    check("w_sum", 64'(out_put_w), 64'd9);
    check("w_cout", 64'(carry_out_w), 64'(1'b0));
    tick();
`ifdef ADDER_SEQ_SUBTRACT_EN
    // Subtraction, with carry_in deliberately set to show that it is ignored.
    in_1_w = 32'd5; in_2_w = 32'd3; carry_in_w = 1'b1; sub_w = 1'b1; start_w = 1'b1;
    tick();
    start_w = 1'b0;
    tick();
    check("sub_done", 64'(done_w), 64'(1'b1));
    check("sub_sum", 64'(out_put_w), 64'd2);
    check("sub_cout", 64'(carry_out_w), 64'(1'b1));
    tick();
    in_1_w = 32'd3; in_2_w = 32'd5; sub_w = 1'b1; start_w = 1'b1;
    tick();
    start_w = 1'b0;
    tick();
    check("subn_done", 64'(done_w), 64'(1'b1));
    check("subn_sum", 64'(out_put_w), 64'hFFFF_FFFE);
    check("subn_cout", 64'(carry_out_w), 64'(1'b0));
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
